// File: rtl/lcd_pattern_gen_pkg.sv
// Shared definitions for the LCD timing/pattern blocks: mode encodings,
// colour-bar table and the line/frame total helper.
package lcd_pkg;

    typedef enum logic [1:0] {
        MODE_BAR   = 2'd0,
        MODE_GRAD  = 2'd1,
        MODE_GRID  = 2'd2,
        MODE_SOLID = 2'd3
    } mode_e;

    // {R,G,B} on/off per bar: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [2:0] BAR_COLORS [8] = '{
        3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
    };

    function automatic int unsigned axis_total(input int unsigned sync_len,
                                               input int unsigned bp_len,
                                               input int unsigned active_len,
                                               input int unsigned fp_len);
        return sync_len + bp_len + active_len + fp_len;
    endfunction

endpackage

// File: rtl/lcd_pattern_gen_if.sv
// Panel-side bus of the pattern generator: pattern controls in, panel pins out.
interface lcd_pattern_gen_if #(
    parameter int COLOR_W = 8
);
    logic [1:0]           mode;
    logic [3*COLOR_W-1:0] solid_rgb;
    logic                 lcd_de;
    logic                 lcd_hs;
    logic                 lcd_vs;
    logic                 lcd_bl;
    logic [3*COLOR_W-1:0] lcd_rgb;
    logic                 frame_start;
    logic [15:0]          pix_x;
    logic [15:0]          pix_y;

    modport master (
        input  mode, solid_rgb,
        output lcd_de, lcd_hs, lcd_vs, lcd_bl, lcd_rgb, frame_start, pix_x, pix_y
    );

    modport slave (
        output mode, solid_rgb,
        input  lcd_de, lcd_hs, lcd_vs, lcd_bl, lcd_rgb, frame_start, pix_x, pix_y
    );
endinterface

// File: rtl/lcd_pattern_gen_timing.sv
// lcd_timing_gen: h/v counters with unregistered sync, DE and x/y decode.
// Consumers register these to get one cycle of latency from the counters.
module lcd_timing_gen import lcd_pkg::*; #(
    parameter int H_ACTIVE = 480,
    parameter int H_FP     = 8,
    parameter int H_SYNC   = 4,
    parameter int H_BP     = 43,
    parameter int V_ACTIVE = 272,
    parameter int V_FP     = 8,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 12
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    output logic        hs_o,
    output logic        vs_o,
    output logic        de_o,
    output logic        frame_end_o,
    output logic [15:0] x_o,
    output logic [15:0] y_o
);
    localparam int H_TOTAL = int'(axis_total(H_SYNC, H_BP, H_ACTIVE, H_FP));
    localparam int V_TOTAL = int'(axis_total(V_SYNC, V_BP, V_ACTIVE, V_FP));
    localparam int H_OFF   = H_SYNC + H_BP;
    localparam int V_OFF   = V_SYNC + V_BP;

    logic [15:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic        h_last, v_last, h_act, v_act;

    always_comb begin
        h_last  = (h_cnt_q == 16'(H_TOTAL - 1));
        v_last  = (v_cnt_q == 16'(V_TOTAL - 1));
        h_cnt_d = h_last ? '0 : h_cnt_q + 16'd1;
        v_cnt_d = v_cnt_q;
        if (h_last) begin
            v_cnt_d = v_last ? '0 : v_cnt_q + 16'd1;
        end
        h_act       = (h_cnt_q >= 16'(H_OFF)) && (h_cnt_q < 16'(H_OFF + H_ACTIVE));
        v_act       = (v_cnt_q >= 16'(V_OFF)) && (v_cnt_q < 16'(V_OFF + V_ACTIVE));
        hs_o        = (h_cnt_q < 16'(H_SYNC));
        vs_o        = (v_cnt_q < 16'(V_SYNC));
        de_o        = h_act && v_act;
        x_o         = h_cnt_q - 16'(H_OFF);
        y_o         = v_cnt_q - 16'(V_OFF);
        frame_end_o = h_last && v_last;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end
endmodule

// File: rtl/lcd_pattern_gen.sv
// LCD test-pattern generator: frame-latched mode, pattern mux and registered panel outputs.
// Optional LCD_PATGEN_BORDER_EN forces the active-area perimeter to white in every mode.
module lcd_pattern_gen import lcd_pkg::*; #(
    parameter int H_ACTIVE = 480,
    parameter int H_FP     = 8,
    parameter int H_SYNC   = 4,
    parameter int H_BP     = 43,
    parameter int V_ACTIVE = 272,
    parameter int V_FP     = 8,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 12,
    parameter bit SYNC_POL = 1'b0,
    parameter int COLOR_W  = 8,
    parameter int GRID     = 16
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    lcd_pattern_gen_if.master   bus
);
    localparam int BAR_W  = H_ACTIVE / 8;
    localparam int GRID_B = $clog2(GRID);

    logic                 tg_hs, tg_vs, tg_de, tg_frame_end;
    logic [15:0]          tg_x, tg_y;
    mode_e                mode_q;
    logic [2:0]           bar_idx_q;
    logic [15:0]          bar_pix_q;
    logic [2:0]           bar_c;
    logic [3*COLOR_W-1:0] rgb_d, rgb_q;
    logic                 de_q, hs_q, vs_q, bl_q, fs_q;
    logic [15:0]          x_q, y_q;

    lcd_timing_gen #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_timing (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .hs_o        (tg_hs),
        .vs_o        (tg_vs),
        .de_o        (tg_de),
        .frame_end_o (tg_frame_end),
        .x_o         (tg_x),
        .y_o         (tg_y)
    );

    always_comb begin
        bar_c = BAR_COLORS[bar_idx_q];
        rgb_d = '0;
        case (mode_q)
            MODE_BAR:   rgb_d = {{COLOR_W{bar_c[2]}}, {COLOR_W{bar_c[1]}}, {COLOR_W{bar_c[0]}}};
            MODE_GRAD:  rgb_d = {3{tg_x[COLOR_W-1:0]}};
            MODE_GRID:  rgb_d = (tg_x[GRID_B-1:0] == '0 || tg_y[GRID_B-1:0] == '0) ? '1 : '0;
            MODE_SOLID: rgb_d = bus.solid_rgb;
            default:    rgb_d = '0;
        endcase
`ifdef LCD_PATGEN_BORDER_EN
        if (tg_x == '0 || tg_x == 16'(H_ACTIVE - 1) || tg_y == '0 || tg_y == 16'(V_ACTIVE - 1)) begin
            rgb_d = '1;
        end
`endif
        if (!tg_de) begin
            rgb_d = '0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            mode_q    <= MODE_BAR;
            bar_idx_q <= '0;
            bar_pix_q <= '0;
            de_q      <= 1'b0;
            hs_q      <= ~SYNC_POL;
            vs_q      <= ~SYNC_POL;
            bl_q      <= 1'b0;
            fs_q      <= 1'b0;
            rgb_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
        end else begin
            if (tg_frame_end) begin
                mode_q <= mode_e'(bus.mode);
            end
            // Bar counter restarts every line; the last bar keeps counting to absorb the remainder
            if (!tg_de) begin
                bar_idx_q <= '0;
                bar_pix_q <= '0;
            end else if (bar_pix_q == 16'(BAR_W - 1) && bar_idx_q != 3'd7) begin
                bar_idx_q <= bar_idx_q + 3'd1;
                bar_pix_q <= '0;
            end else begin
                bar_pix_q <= bar_pix_q + 16'd1;
            end
            de_q  <= tg_de;
            hs_q  <= tg_hs ? SYNC_POL : ~SYNC_POL;
            vs_q  <= tg_vs ? SYNC_POL : ~SYNC_POL;
            bl_q  <= 1'b1;
            fs_q  <= tg_de && tg_x == '0 && tg_y == '0;
            rgb_q <= rgb_d;
            if (tg_de) begin
                x_q <= tg_x;
                y_q <= tg_y;
            end
        end
    end

    assign bus.lcd_de      = de_q;
    assign bus.lcd_hs      = hs_q;
    assign bus.lcd_vs      = vs_q;
    assign bus.lcd_bl      = bl_q;
    assign bus.frame_start = fs_q;
    assign bus.lcd_rgb     = rgb_q;
    assign bus.pix_x       = x_q;
    assign bus.pix_y       = y_q;
endmodule
